console_vga_display: RTL and testbench

- Reader end of the console text-buffer interface that the debugger drives.
- Owns the 80x30 character buffer, which is written through the console_addr/console_write/console_data port.
- Scans the buffer out continuously as 640x480@60 VGA, using an 8x16 font with white-on-black, 12-bit RGB.
- Sits between the debugger block and the board VGA pins.

---
 rtl/console_pkg.sv | 50 +++++
 rtl/console_font_rom.sv | 24 ++
 rtl/console_vga_display.sv | 188 ++++++++++++++++++
 tb/tb_console_vga_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// console_pkg: console text geometry, 640x480@60 VGA timing, scan pipeline types and the
// built-in 8x16 font image shared by the console display and its font ROM.
package console_pkg;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    localparam logic [11:0] CONSOLE_DEPTH = 12'(COLS * ROWS);
    localparam logic [11:0] CONSOLE_LAST  = CONSOLE_DEPTH - 12'd1;

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_TOTAL      = 10'd800;

    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Per-pixel control that travels down the scan pipeline beside the buffer/ROM reads.
    typedef struct packed {
        logic       valid;
        logic       visible;
        logic       hsync_n;
        logic       vsync_n;
        logic [2:0] px;
    } scan_ctl_t;

    // Font image: one 8-pixel row per (code, line), MSB is the leftmost pixel.
    // Control codes, DEL and space are empty; glyphs occupy lines 2..13 of the cell.
    function automatic logic [7:0] font_glyph_row(input logic [6:0] code, input logic [3:0] line);
        logic [7:0] bits;
        bits = 8'h00;
        if ((code > 7'h20) && (code != 7'h7F) && (line >= 4'd2) && (line <= 4'd13)) begin
            bits = {code, line[0]} ^ {line, ~line};
            if (bits == 8'h00) begin
                bits = 8'h18;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/console_font_rom.sv
// console_font_rom: 2048x8 synchronous-read glyph ROM addressed by {char[6:0], line[3:0]}.
// Table contents are the console_pkg font image; entries for 0x00..0x1F and 0x7F are all zero.
module console_font_rom
    import console_pkg::*;
(
    input  logic        clock,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [7:0] data_d;
    logic [7:0] data_q;

    always_comb begin
        data_d = font_glyph_row(addr[10:4], addr[3:0]);
    end

    always_ff @(posedge clock) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/console_vga_display.sv
// console_vga_display: owns the 80x30 console character buffer and scans it out as 640x480@60
// VGA with 8x16 glyphs in RGB444. Define CONSOLE_CURSOR_EN for a blinking underline cursor.
module console_vga_display
    import console_pkg::*;
#(
    parameter rgb444_t FG_COLOR = 12'hFFF,
    parameter rgb444_t BG_COLOR = 12'h000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] console_addr,
    input  logic        console_write,
    input  logic [7:0]  console_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [11:0] vga_rgb
);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       h_wrap;
    logic       v_wrap;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        h_wrap  = (h_cnt_q == H_TOTAL - 10'd1);
        v_wrap  = (v_cnt_q == V_TOTAL - 10'd1);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // NOTE: flops update with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Stage 0: cell address and control flags for the current raster position.
    logic [6:0]  s0_col;
    logic [4:0]  s0_row;
    logic [11:0] s0_addr;
    logic [11:0] rd_addr;
    scan_ctl_t   s1_ctl_d, s1_ctl_q;
    logic [3:0]  s1_line_d, s1_line_q;

    always_comb begin
        s0_col            = h_cnt_q[9:3];
        s0_row            = v_cnt_q[8:4];
        s0_addr           = ({7'd0, s0_row} << 6) + ({7'd0, s0_row} << 4) + {5'd0, s0_col};
        s1_ctl_d.valid    = 1'b1;
        s1_ctl_d.visible  = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
        s1_ctl_d.hsync_n  = !((h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END));
        s1_ctl_d.vsync_n  = !((v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END));
        s1_ctl_d.px       = h_cnt_q[2:0];
        s1_line_d         = v_cnt_q[3:0];
        // Blanking positions can form addresses past the buffer end; park them on cell 0.
        rd_addr           = s1_ctl_d.visible ? s0_addr : 12'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_ctl_q  <= '0;
            s1_line_q <= '0;
        end else begin
            s1_ctl_q  <= s1_ctl_d;
            s1_line_q <= s1_line_d;
        end
    end

    // Stage 1: character buffer, read-before-write so a colliding scan sees the old byte.
    logic [7:0] char_mem [0:COLS*ROWS-1];
    logic [7:0] s1_char_q;
    logic       wr_en;

    assign wr_en = console_write && (console_addr < CONSOLE_DEPTH);

    // NOTE: the buffer and its read register have no reset; contents must survive reset and map to block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            char_mem[console_addr] <= console_data;
        end
        s1_char_q <= char_mem[rd_addr];
    end

    // Stage 2: glyph row lookup; codes with bit 7 set alias into the ROM and are blanked here.
    logic [7:0] s2_bitmap;
    scan_ctl_t  s2_ctl_q;
    logic       s2_glyph_en_d, s2_glyph_en_q;

    console_font_rom u_font_rom (
        .clock (clock),
        .addr  ({s1_char_q[6:0], s1_line_q}),
        .data  (s2_bitmap)
    );

    always_comb begin
        s2_glyph_en_d = ~s1_char_q[7];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_ctl_q      <= '0;
            s2_glyph_en_q <= 1'b0;
        end else begin
            s2_ctl_q      <= s1_ctl_q;
            s2_glyph_en_q <= s2_glyph_en_d;
        end
    end

`ifdef CONSOLE_CURSOR_EN
    logic [11:0] cursor_q, cursor_d;
    logic [4:0]  frame_cnt_q, frame_cnt_d;
    logic        s1_cursor_d, s1_cursor_q, s2_cursor_q;

    always_comb begin
        cursor_d = cursor_q;
        if (wr_en) begin
            cursor_d = (console_addr == CONSOLE_LAST) ? 12'd0 : console_addr + 12'd1;
        end
        frame_cnt_d = (h_wrap && v_wrap) ? frame_cnt_q + 5'd1 : frame_cnt_q;
        // Underline on font lines 14..15 of the cursor cell while the blink phase is on.
        s1_cursor_d = s1_ctl_d.visible && (s0_addr == cursor_q) &&
                      (v_cnt_q[3:1] == 3'b111) && frame_cnt_q[4];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cursor_q    <= '0;
            frame_cnt_q <= '0;
            s1_cursor_q <= 1'b0;
            s2_cursor_q <= 1'b0;
        end else begin
            cursor_q    <= cursor_d;
            frame_cnt_q <= frame_cnt_d;
            s1_cursor_q <= s1_cursor_d;
            s2_cursor_q <= s1_cursor_q;
        end
    end
`endif

    // Stage 3: pixel select and output register; syncs ride the same pipeline as the pixels.
    logic    pixel_on;
    logic    hsync_d, hsync_q;
    logic    vsync_d, vsync_q;
    rgb444_t rgb_d, rgb_q;

    always_comb begin
        pixel_on = s2_bitmap[3'd7 - s2_ctl_q.px] && s2_glyph_en_q;
`ifdef CONSOLE_CURSOR_EN
        pixel_on = pixel_on || s2_cursor_q;
`endif
        hsync_d = 1'b1;
        vsync_d = 1'b1;
        rgb_d   = '0;
        if (s2_ctl_q.valid) begin
            hsync_d = s2_ctl_q.hsync_n;
            vsync_d = s2_ctl_q.vsync_n;
            if (s2_ctl_q.visible) begin
                rgb_d = pixel_on ? FG_COLOR : BG_COLOR;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_rgb   = rgb_q;

endmodule

// File: tb/tb_console_vga_display.sv
// tb_console_vga_display: random console writes checked every pixel clock against a
// raster-position reference model, plus reset, mid-frame reset and hsync timing checks.
module tb_console_vga_display;
    import console_pkg::*;

    logic        clock;
    logic        reset;
    logic [11:0] console_addr;
    logic        console_write;
    logic [7:0]  console_data;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [11:0] vga_rgb;

    console_vga_display dut (
        .clock         (clock),
        .reset         (reset),
        .console_addr  (console_addr),
        .console_write (console_write),
        .console_data  (console_data),
        .vga_hsync     (vga_hsync),
        .vga_vsync     (vga_vsync),
        .vga_rgb       (vga_rgb)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    // A scan sample: raster position and the character the buffer held when it was read.
    typedef struct {
        int         h;
        int         v;
        logic [7:0] ch;
    } scan_t;

    localparam logic [31:0] IDLE = 32'h0000_3000;

    scan_t      scan_q[$];
    logic [7:0] model_mem [2400];
    int         frame_pos;
    bit         synced;
    logic       prev_hsync;
    int         hsync_falls[$];
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Expected {hsync, vsync, rgb} for raster position (h, v) showing character ch.
    function automatic logic [31:0] expect_pixel(input int h, input int v, input logic [7:0] ch);
        logic       hs;
        logic       vs;
        logic [11:0] rgb;
        logic [7:0] row;
        hs  = !(h >= 656 && h < 752);
        vs  = !(v >= 490 && v < 492);
        rgb = 12'h000;
        if (h < 640 && v < 480 && ch >= 8'h20 && ch < 8'h7F) begin
            row = font_glyph_row(ch[6:0], 4'(v % 16));
            if (row[7 - (h % 8)]) rgb = 12'hFFF;
        end
        return {18'd0, hs, vs, rgb};
    endfunction

    // One pixel clock: check outputs, record what the next edge scans, apply the write, clock.
    task automatic step(input logic rst, input logic we, input int addr, input logic [7:0] data);
        scan_t s;
        int    h;
        int    v;
        @(negedge clock);
        if (synced) begin
            if (frame_pos < 3) begin
                check($sformatf("idle pos=%0d", frame_pos),
                      {18'd0, vga_hsync, vga_vsync, vga_rgb}, IDLE);
            end else begin
                s = scan_q.pop_front();
                check($sformatf("pixel h=%0d v=%0d ch=%02h", s.h, s.v, s.ch),
                      {18'd0, vga_hsync, vga_vsync, vga_rgb}, expect_pixel(s.h, s.v, s.ch));
            end
            if (prev_hsync === 1'b1 && vga_hsync === 1'b0 && hsync_falls.size() < 2)
                hsync_falls.push_back(frame_pos);
            prev_hsync = vga_hsync;
        end
        if (rst) begin
            scan_q.delete();
        end else begin
            h    = frame_pos % 800;
            v    = (frame_pos / 800) % 525;
            s.h  = h;
            s.v  = v;
            s.ch = (h < 640 && v < 480) ? model_mem[(v / 16) * 80 + h / 8] : 8'h00;
            scan_q.push_back(s);
        end
        if (we && addr < 2400) model_mem[addr] = data;
        reset         = rst;
        console_write = we;
        console_addr  = 12'(addr);
        console_data  = data;
        @(posedge clock);
        if (rst) begin
            frame_pos = 0;
            synced    = 1'b1;
        end else begin
            frame_pos++;
        end
    endtask

    // Random write traffic; with collide set, every visible line also writes the cell being read.
    task automatic random_step(input bit collide);
        int   addr;
        logic we;
        int   h;
        int   v;
        h  = frame_pos % 800;
        v  = (frame_pos / 800) % 525;
        we = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 3))
            0, 1:    addr = $urandom_range(0, 399);
            2:       addr = $urandom_range(400, 2399);
            default: addr = $urandom_range(2400, 4095);
        endcase
        if (collide && h == 20 && v < 480) begin
            we   = 1'b1;
            addr = (v / 16) * 80 + 2;
        end
        step(1'b0, we, addr, 8'($urandom));
    endtask

    initial begin
        logic [7:0] d;
        reset         = 1'b1;
        console_write = 1'b0;
        console_addr  = '0;
        console_data  = '0;
        synced        = 1'b0;
        frame_pos     = 0;
        prev_hsync    = 1'b1;
        n_checks      = 0;
        n_pass        = 0;

        // Load the whole buffer while the scan is held in reset.
        for (int a = 0; a < 2400; a++) begin
            if (a == 0)        d = 8'h50;
            else if (a == 1)   d = 8'h41;
            else if (a < 400)  d = 8'($urandom);
            else               d = 8'h00;
            step(1'b1, 1'b1, a, d);
        end

        // Free-run with random writes up to h=300, v=20, then a one-cycle reset.
        while (frame_pos < 20 * 800 + 300) random_step(1'b0);
        step(1'b1, 1'b0, 0, 8'h00);

        // Restarted frame: retained glyphs plus same-cycle read/write collisions.
        repeat (48 * 800) random_step(1'b1);

        check("first hsync fall", (hsync_falls.size() > 0) ? hsync_falls[0] : -1, 659);
        check("hsync period",
              (hsync_falls.size() > 1) ? hsync_falls[1] - hsync_falls[0] : -1, 800);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
